// File: rtl/nete_rx_packer_if.sv
// Bus bundle for nete_rx_packer: AXI-Stream ingress beats plus the packet and
// byte-count FIFO write ports. "master" is the packer side, "slave" the environment.
`timescale 1ns/1ps

interface nete_rx_packer_if #(
  parameter int IN_W    = 64,
  parameter int OUT_W   = 256,
  parameter int USEDW_W = 7,
  parameter int BCNT_W  = 64
) ();
  logic [IN_W-1:0]     s_tdata;
  logic [IN_W/8-1:0]   s_tkeep;
  logic                s_tvalid;
  logic                s_tlast;
  logic                s_tready;
  logic [OUT_W-1:0]    fifo_pkt_data;
  logic                fifo_pkt_wren;
  logic                fifo_pkt_full;
  logic [USEDW_W-1:0]  fifo_pkt_usedword;
  logic [BCNT_W-1:0]   fifo_bcnt_data;
  logic                fifo_bcnt_wren;
  logic                fifo_bcnt_full;
  logic                err_keep;

  modport master (
    input  s_tdata, s_tkeep, s_tvalid, s_tlast,
    input  fifo_pkt_full, fifo_pkt_usedword, fifo_bcnt_full,
    output s_tready, fifo_pkt_data, fifo_pkt_wren,
    output fifo_bcnt_data, fifo_bcnt_wren, err_keep
  );

  modport slave (
    output s_tdata, s_tkeep, s_tvalid, s_tlast,
    output fifo_pkt_full, fifo_pkt_usedword, fifo_bcnt_full,
    input  s_tready, fifo_pkt_data, fifo_pkt_wren,
    input  fifo_bcnt_data, fifo_bcnt_wren, err_keep
  );
endinterface

// File: rtl/nete_rx_packer.sv
// AXI-Stream ingress packer: packs OUT_W/IN_W beats per packet-FIFO word and writes one
// byte count per packet. Optional statistics counters via `NETE_RX_PACKER_STATS_EN.
`timescale 1ns/1ps

module nete_rx_packer #(
  parameter int IN_W         = 64,
  parameter int OUT_W        = 256,
  parameter int USEDW_W      = 7,
  parameter int AFULL_THRESH = 64,
  parameter int BCNT_W       = 64
) (
  input  logic               clk,
  input  logic               reset_,
  nete_rx_packer_if.master   bus
`ifdef NETE_RX_PACKER_STATS_EN
  ,
  output logic [31:0]        stat_pkt_cnt,
  output logic [31:0]        stat_word_cnt,
  output logic [15:0]        stat_keep_err_cnt
`endif
);

  localparam int R      = OUT_W / IN_W;
  localparam int KEEP_W = IN_W / 8;
  localparam int LANE_W = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_WRITE
  } state_t;

  state_t             r_state;
  logic               r_ready;
  logic [LANE_W-1:0]  r_lane;
  logic [OUT_W-1:0]   r_buf;
  logic [OUT_W-1:0]   r_pkt_data;
  logic               r_pkt_wren;
  logic [BCNT_W-1:0]  r_acc;
  logic [BCNT_W-1:0]  r_bcnt_data;
  logic               r_bcnt_wren;
  logic               r_err_keep;

  logic               w_fire;
  logic               w_word_done;
  logic               w_keep_ok;
  logic [KEEP_W-1:0]  w_keep_inc;
  logic [BCNT_W:0]    w_sum;
  logic [BCNT_W-1:0]  w_next_acc;
  logic [OUT_W-1:0]   w_merged;

  function automatic logic [BCNT_W:0] popcount(input logic [KEEP_W-1:0] keep);
    logic [BCNT_W:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++) n = n + (BCNT_W+1)'(keep[i]);
    return n;
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_fire      = bus.s_tvalid && r_ready;
    w_word_done = (r_lane == LANE_W'(R - 1)) || bus.s_tlast;
    w_keep_inc  = bus.s_tkeep + KEEP_W'(1);
    // A contiguous-from-bit-0 mask is 2^n-1: adding one clears every set bit.
    w_keep_ok   = (bus.s_tkeep != '0) && ((bus.s_tkeep & w_keep_inc) == '0);
    w_sum       = {1'b0, r_acc} + popcount(bus.s_tkeep);
    w_next_acc  = w_sum[BCNT_W] ? '1 : w_sum[BCNT_W-1:0];
    w_merged    = r_buf;
    for (int k = 0; k < R; k++) begin
      if (r_lane == LANE_W'(k)) w_merged[k*IN_W +: IN_W] = bus.s_tdata;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_lane      <= '0;
      r_buf       <= '0;
      r_pkt_data  <= '0;
      r_pkt_wren  <= 1'b0;
      r_acc       <= '0;
      r_bcnt_data <= '0;
      r_bcnt_wren <= 1'b0;
      r_err_keep  <= 1'b0;
    end else begin
      // Registered throttle: the FIFO must absorb up to two beats after this drops.
      r_ready     <= !(int'(bus.fifo_pkt_usedword) >= AFULL_THRESH) &&
                     !bus.fifo_pkt_full && !bus.fifo_bcnt_full;
      r_pkt_wren  <= 1'b0;
      r_bcnt_wren <= 1'b0;
      r_err_keep  <= w_fire && !w_keep_ok;

      if (w_fire) begin
        if (w_word_done) begin
          // Buffer restarts at zero so unused lanes of a tlast word read as zero.
          r_pkt_data <= w_merged;
          r_pkt_wren <= 1'b1;
          r_buf      <= '0;
          r_lane     <= '0;
        end else begin
          r_buf      <= w_merged;
          r_lane     <= r_lane + LANE_W'(1);
        end

        if (bus.s_tlast) begin
          r_bcnt_data <= w_next_acc;
          r_bcnt_wren <= 1'b1;
          r_acc       <= '0;
          r_state     <= ST_WRITE;
        end else begin
          r_acc       <= w_next_acc;
          r_state     <= ST_ACCUM;
        end
      end else if (r_state == ST_WRITE) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign bus.s_tready       = r_ready;
  assign bus.fifo_pkt_data  = r_pkt_data;
  assign bus.fifo_pkt_wren  = r_pkt_wren;
  assign bus.fifo_bcnt_data = r_bcnt_data;
  assign bus.fifo_bcnt_wren = r_bcnt_wren;
  assign bus.err_keep       = r_err_keep;

`ifdef NETE_RX_PACKER_STATS_EN
  logic [31:0] r_stat_pkt;
  logic [31:0] r_stat_word;
  logic [15:0] r_stat_err;
  logic [31:0] r_pkt_words;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_stat_pkt  <= '0;
      r_stat_word <= '0;
      r_stat_err  <= '0;
      r_pkt_words <= '0;
    end else begin
      if (r_bcnt_wren) r_stat_pkt  <= r_stat_pkt + 32'd1;
      if (r_pkt_wren)  r_stat_word <= r_stat_word + 32'd1;
      if (r_err_keep)  r_stat_err  <= r_stat_err + 16'd1;
      if (r_pkt_wren)  r_pkt_words <= r_bcnt_wren ? '0 : r_pkt_words + 32'd1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_ && r_bcnt_wren)
      $display("nete_rx_packer: packet bytes=%0d words=%0d", r_bcnt_data, r_pkt_words + 32'd1);
  end
`endif

  assign stat_pkt_cnt      = r_stat_pkt;
  assign stat_word_cnt     = r_stat_word;
  assign stat_keep_err_cnt = r_stat_err;
`endif

endmodule

// File: tb/tb_nete_rx_packer.sv
// Scoreboard bench for nete_rx_packer: a 64->256 instance for the packing, byte-count,
// keep-error and backpressure cases and a 64->128 instance for back-to-back plus reset.
`timescale 1ns/1ps

module tb_nete_rx_packer;
  localparam int IN_W    = 64;
  localparam int OW_A    = 256;
  localparam int OW_B    = 128;
  localparam int USEDW_W = 7;
  localparam int BCNT_W  = 64;

  logic clk    = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  nete_rx_packer_if #(.IN_W(IN_W), .OUT_W(OW_A), .USEDW_W(USEDW_W), .BCNT_W(BCNT_W)) bus_a ();
  nete_rx_packer_if #(.IN_W(IN_W), .OUT_W(OW_B), .USEDW_W(USEDW_W), .BCNT_W(BCNT_W)) bus_b ();

`ifdef NETE_RX_PACKER_STATS_EN
  logic [31:0] spk_a, swd_a, spk_b, swd_b;
  logic [15:0] ser_a, ser_b;
`endif

  nete_rx_packer #(.IN_W(IN_W), .OUT_W(OW_A), .USEDW_W(USEDW_W), .AFULL_THRESH(64), .BCNT_W(BCNT_W)) dut_a (
    .clk(clk), .reset_(reset_), .bus(bus_a.master)
`ifdef NETE_RX_PACKER_STATS_EN
    , .stat_pkt_cnt(spk_a), .stat_word_cnt(swd_a), .stat_keep_err_cnt(ser_a)
`endif
  );

  nete_rx_packer #(.IN_W(IN_W), .OUT_W(OW_B), .USEDW_W(USEDW_W), .AFULL_THRESH(64), .BCNT_W(BCNT_W)) dut_b (
    .clk(clk), .reset_(reset_), .bus(bus_b.master)
`ifdef NETE_RX_PACKER_STATS_EN
    , .stat_pkt_cnt(spk_b), .stat_word_cnt(swd_b), .stat_keep_err_cnt(ser_b)
`endif
  );

  // Scoreboards: expectations pushed by the tests, popped by the monitors.
  logic [OW_A-1:0]   exp_word_a[$];
  logic [BCNT_W-1:0] exp_bcnt_a[$];
  logic [OW_B-1:0]   exp_word_b[$];
  logic [BCNT_W-1:0] exp_bcnt_b[$];
  logic [OW_A-1:0]   ew_a;
  logic [OW_B-1:0]   ew_b;
  logic [BCNT_W-1:0] eb_a, eb_b;
  int wren_a = 0, bwr_a = 0, err_a = 0;
  int wren_b = 0, bwr_b = 0;

  function automatic logic [63:0] beat(input logic [7:0] v);
    return {8{v}};
  endfunction

  always @(negedge clk) begin
    if (reset_) begin
      if (bus_a.fifo_pkt_wren) begin
        wren_a++;
        checks++;
        if (exp_word_a.size() == 0) begin
          failures++;
          $display("FAIL pkt_word_a: unexpected write got=%h expected=none", bus_a.fifo_pkt_data);
        end else begin
          ew_a = exp_word_a.pop_front();
          if (bus_a.fifo_pkt_data !== ew_a) begin
            failures++;
            $display("FAIL pkt_word_a: got=%h expected=%h", bus_a.fifo_pkt_data, ew_a);
          end
        end
      end
      if (bus_a.fifo_bcnt_wren) begin
        bwr_a++;
        checks++;
        if (exp_bcnt_a.size() == 0) begin
          failures++;
          $display("FAIL bcnt_a: unexpected write got=%0d expected=none", bus_a.fifo_bcnt_data);
        end else begin
          eb_a = exp_bcnt_a.pop_front();
          if (bus_a.fifo_bcnt_data !== eb_a) begin
            failures++;
            $display("FAIL bcnt_a: got=%0d expected=%0d", bus_a.fifo_bcnt_data, eb_a);
          end
        end
        checks++;
        if (bus_a.fifo_pkt_wren !== 1'b1) begin
          failures++;
          $display("FAIL bcnt_align_a: pkt_wren=%b expected=1 with bcnt_wren", bus_a.fifo_pkt_wren);
        end
      end
      if (bus_a.err_keep) err_a++;
    end
  end

  always @(negedge clk) begin
    if (reset_) begin
      if (bus_b.fifo_pkt_wren) begin
        wren_b++;
        checks++;
        if (exp_word_b.size() == 0) begin
          failures++;
          $display("FAIL pkt_word_b: unexpected write got=%h expected=none", bus_b.fifo_pkt_data);
        end else begin
          ew_b = exp_word_b.pop_front();
          if (bus_b.fifo_pkt_data !== ew_b) begin
            failures++;
            $display("FAIL pkt_word_b: got=%h expected=%h", bus_b.fifo_pkt_data, ew_b);
          end
        end
      end
      if (bus_b.fifo_bcnt_wren) begin
        bwr_b++;
        checks++;
        if (exp_bcnt_b.size() == 0) begin
          failures++;
          $display("FAIL bcnt_b: unexpected write got=%0d expected=none", bus_b.fifo_bcnt_data);
        end else begin
          eb_b = exp_bcnt_b.pop_front();
          if (bus_b.fifo_bcnt_data !== eb_b) begin
            failures++;
            $display("FAIL bcnt_b: got=%0d expected=%0d", bus_b.fifo_bcnt_data, eb_b);
          end
        end
      end
    end
  end

  // Drive one beat from a negedge; returns at the negedge after it was accepted.
  task automatic send_a(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    bus_a.s_tdata = d; bus_a.s_tkeep = k; bus_a.s_tlast = l; bus_a.s_tvalid = 1'b1;
    while (bus_a.s_tready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (bus_a.s_tready !== 1'b1) begin
      failures++;
      $display("FAIL send_a_ready_timeout: tready=%b expected=1", bus_a.s_tready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_b(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    bus_b.s_tdata = d; bus_b.s_tkeep = k; bus_b.s_tlast = l; bus_b.s_tvalid = 1'b1;
    while (bus_b.s_tready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (bus_b.s_tready !== 1'b1) begin
      failures++;
      $display("FAIL send_b_ready_timeout: tready=%b expected=1", bus_b.s_tready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_a();
    bus_a.s_tvalid = 1'b0; bus_a.s_tlast = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain_a(input string name);
    int n = 0;
    while ((exp_word_a.size() != 0 || exp_bcnt_a.size() != 0) && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (exp_word_a.size() != 0 || exp_bcnt_a.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: words_left=%0d bcnt_left=%0d expected=0", name, exp_word_a.size(), exp_bcnt_a.size());
    end
  endtask

  task automatic test_reset();
    bus_a.s_tvalid = 0; bus_a.s_tlast = 0; bus_a.s_tdata = '0; bus_a.s_tkeep = '0;
    bus_a.fifo_pkt_full = 0; bus_a.fifo_bcnt_full = 0; bus_a.fifo_pkt_usedword = '0;
    bus_b.s_tvalid = 0; bus_b.s_tlast = 0; bus_b.s_tdata = '0; bus_b.s_tkeep = '0;
    bus_b.fifo_pkt_full = 0; bus_b.fifo_bcnt_full = 0; bus_b.fifo_pkt_usedword = '0;
    reset_ = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.s_tready, bus_a.fifo_pkt_wren, bus_a.fifo_bcnt_wren, bus_a.err_keep} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strobes: got=%b expected=0000",
               {bus_a.s_tready, bus_a.fifo_pkt_wren, bus_a.fifo_bcnt_wren, bus_a.err_keep});
    end
    checks++;
    if (bus_a.fifo_pkt_data !== '0) begin
      failures++;
      $display("FAIL reset_pkt_data: got=%h expected=0", bus_a.fifo_pkt_data);
    end
    checks++;
    if (bus_a.fifo_bcnt_data !== '0) begin
      failures++;
      $display("FAIL reset_bcnt_data: got=%h expected=0", bus_a.fifo_bcnt_data);
    end
    reset_ = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.s_tready !== 1'b1 || bus_b.s_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got=%b%b expected=11", bus_a.s_tready, bus_b.s_tready);
    end
  endtask

  task automatic test_full_packet();
    int e0 = err_a;
    exp_word_a.push_back({beat(8'h04), beat(8'h03), beat(8'h02), beat(8'h01)});
    exp_word_a.push_back({beat(8'h08), beat(8'h07), beat(8'h06), beat(8'h05)});
    exp_bcnt_a.push_back(64'd64);
    for (int i = 1; i <= 8; i++) begin
      send_a(beat(8'(i)), 8'hFF, i == 8);
      if (i == 4 || i == 8) begin
        checks++;
        if ({bus_a.fifo_pkt_wren, bus_a.fifo_bcnt_wren} !== {1'b1, i == 8}) begin
          failures++;
          $display("FAIL full_latency_beat%0d: wren/bcnt_wren=%b%b expected=1%b",
                   i, bus_a.fifo_pkt_wren, bus_a.fifo_bcnt_wren, i == 8);
        end
      end
    end
    idle_a();
    drain_a("full_packet");
    checks++;
    if (err_a !== e0) begin
      failures++;
      $display("FAIL full_err_keep: pulses=%0d expected=0", err_a - e0);
    end
  endtask

  task automatic test_partial_last();
    int e0 = err_a;
    logic [63:0] d7 = 64'h0000_0707_0707_0707;
    exp_word_a.push_back({beat(8'h04), beat(8'h03), beat(8'h02), beat(8'h01)});
    exp_word_a.push_back({64'h0, d7, beat(8'h06), beat(8'h05)});
    exp_bcnt_a.push_back(64'd54);
    for (int i = 1; i <= 6; i++) send_a(beat(8'(i)), 8'hFF, 1'b0);
    send_a(d7, 8'h3F, 1'b1);
    idle_a();
    drain_a("partial_last");
    checks++;
    if (err_a !== e0) begin
      failures++;
      $display("FAIL partial_err_keep: pulses=%0d expected=0", err_a - e0);
    end
  endtask

  task automatic test_single_beat();
    logic [63:0] d = 64'hDEAD_BEEF_CAFE_F00D;
    exp_word_a.push_back({192'h0, d});
    exp_bcnt_a.push_back(64'd4);
    send_a(d, 8'h0F, 1'b1);
    bus_a.s_tvalid = 1'b0; bus_a.s_tlast = 1'b0;
    checks++;
    if ({bus_a.fifo_pkt_wren, bus_a.fifo_bcnt_wren} !== 2'b11) begin
      failures++;
      $display("FAIL single_latency: wren/bcnt_wren=%b%b expected=11", bus_a.fifo_pkt_wren, bus_a.fifo_bcnt_wren);
    end
    @(negedge clk);
    checks++;
    if ({bus_a.fifo_pkt_wren, bus_a.fifo_bcnt_wren} !== 2'b00) begin
      failures++;
      $display("FAIL single_one_cycle: wren/bcnt_wren=%b%b expected=00", bus_a.fifo_pkt_wren, bus_a.fifo_bcnt_wren);
    end
    checks++;
    if (bus_a.fifo_bcnt_data !== 64'd4) begin
      failures++;
      $display("FAIL single_bcnt_hold: got=%0d expected=4", bus_a.fifo_bcnt_data);
    end
    drain_a("single_beat");
  endtask

  task automatic test_keep_err();
    int e0 = err_a;
    exp_word_a.push_back({64'h0, beat(8'h33), beat(8'h22), beat(8'h11)});
    exp_bcnt_a.push_back(64'd20);
    send_a(beat(8'h11), 8'hFF, 1'b0);
    idle_a(); idle_a();
    send_a(beat(8'h22), 8'h5A, 1'b0);
    bus_a.s_tvalid = 1'b0;
    checks++;
    if (bus_a.err_keep !== 1'b1) begin
      failures++;
      $display("FAIL keep_err_pulse: err_keep=%b expected=1", bus_a.err_keep);
    end
    @(negedge clk);
    checks++;
    if (bus_a.err_keep !== 1'b0) begin
      failures++;
      $display("FAIL keep_err_width: err_keep=%b expected=0", bus_a.err_keep);
    end
    idle_a();
    send_a(beat(8'h33), 8'hFF, 1'b1);
    idle_a();
    drain_a("keep_err");
    checks++;
    if (err_a - e0 !== 1) begin
      failures++;
      $display("FAIL keep_err_count: pulses=%0d expected=1", err_a - e0);
    end
  endtask

  task automatic test_backpressure();
    int w0;
    exp_word_a.push_back({beat(8'h04), beat(8'h03), beat(8'h02), beat(8'h01)});
    exp_word_a.push_back({beat(8'h08), beat(8'h07), beat(8'h06), beat(8'h05)});
    exp_bcnt_a.push_back(64'd64);
    send_a(beat(8'h01), 8'hFF, 1'b0);
    send_a(beat(8'h02), 8'hFF, 1'b0);
    bus_a.fifo_pkt_usedword = 7'd64;
    send_a(beat(8'h03), 8'hFF, 1'b0);
    checks++;
    if (bus_a.s_tready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_drop: tready=%b expected=0", bus_a.s_tready);
    end
    w0 = wren_a;
    bus_a.s_tdata = beat(8'h04); bus_a.s_tkeep = 8'hFF; bus_a.s_tlast = 1'b0; bus_a.s_tvalid = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (wren_a !== w0 || bus_a.s_tready !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall: writes=%0d tready=%b expected writes=0 tready=0", wren_a - w0, bus_a.s_tready);
    end
    bus_a.fifo_pkt_usedword = 7'd63;
    for (int i = 4; i <= 8; i++) send_a(beat(8'(i)), 8'hFF, i == 8);
    idle_a();
    drain_a("backpressure");
    bus_a.fifo_pkt_full = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_a.s_tready !== 1'b0) begin
      failures++;
      $display("FAIL bp_pkt_full: tready=%b expected=0", bus_a.s_tready);
    end
    bus_a.fifo_pkt_full = 1'b0;
    bus_a.fifo_bcnt_full = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_a.s_tready !== 1'b0) begin
      failures++;
      $display("FAIL bp_bcnt_full: tready=%b expected=0", bus_a.s_tready);
    end
    bus_a.fifo_bcnt_full = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    exp_word_b.push_back({beat(8'h12), beat(8'h11)});
    exp_word_b.push_back({64'h0, beat(8'h13)});
    exp_bcnt_b.push_back(64'd24);
    send_b(beat(8'h11), 8'hFF, 1'b0);
    send_b(beat(8'h12), 8'hFF, 1'b0);
    send_b(beat(8'h13), 8'hFF, 1'b1);
    send_b(beat(8'h21), 8'hFF, 1'b0);
    reset_ = 1'b0;
    #1;
    checks++;
    if ({bus_b.s_tready, bus_b.fifo_pkt_wren, bus_b.fifo_bcnt_wren, bus_b.err_keep} !== 4'b0 ||
        bus_b.fifo_pkt_data !== '0 || bus_b.fifo_bcnt_data !== '0) begin
      failures++;
      $display("FAIL b2b_reset_outputs: strobes=%b data=%h bcnt=%h expected all 0",
               {bus_b.s_tready, bus_b.fifo_pkt_wren, bus_b.fifo_bcnt_wren, bus_b.err_keep},
               bus_b.fifo_pkt_data, bus_b.fifo_bcnt_data);
    end
    bus_b.s_tvalid = 1'b0; bus_b.s_tlast = 1'b0;
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    repeat (6) @(negedge clk);
    while ((exp_word_b.size() != 0 || exp_bcnt_b.size() != 0) && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (exp_word_b.size() != 0 || exp_bcnt_b.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: words_left=%0d bcnt_left=%0d expected=0", exp_word_b.size(), exp_bcnt_b.size());
    end
    checks++;
    if (wren_b !== 2 || bwr_b !== 1) begin
      failures++;
      $display("FAIL b2b_write_count: pkt=%0d bcnt=%0d expected pkt=2 bcnt=1", wren_b, bwr_b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_packet();
    test_partial_last();
    test_single_beat();
    test_keep_err();
    test_backpressure();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
